hazard_scoreboard: RTL and testbench

Hazard control for the non-forwarding 5-stage pipeline (IF, ID, EX, MEM, WB). It tracks the destination registers of in-flight instructions in a small shift-register scoreboard and detects read-after-write hazards for the instruction in ID. It combines those hazards with the one-cycle load-stall pulse from the load-pending stage and the EX-stage branch flush to produce the PC, IF/ID and ID/EX enable, flush and bubble controls. It also keeps a saturating count of RAW stall cycles for performance monitoring.

---
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard detection and pipeline stall/flush control for a non-forwarding 5-stage pipeline.
// A shift-register scoreboard holds the destination registers still in flight behind ID.
module hazard_scoreboard #(
   parameter int HAZ_DEPTH = 3,
   parameter int CNT_W     = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_id_valid,
   input  logic [4:0]       i_id_rs1_addr,
   input  logic             i_id_rs1_used,
   input  logic [4:0]       i_id_rs2_addr,
   input  logic             i_id_rs2_used,
   input  logic [4:0]       i_id_rd_addr,
   input  logic             i_id_rd_wren,
   input  logic             i_stall_load,
   input  logic             i_flush,
   output logic             o_pc_en,
   output logic             o_ifid_en,
   output logic             o_ifid_flush,
   output logic             o_idex_en,
   output logic             o_idex_bubble,
   output logic             o_raw_stall,
   output logic [CNT_W-1:0] o_raw_stall_cnt
);

   logic [HAZ_DEPTH-1:0] sb_valid;
   logic [4:0]           sb_rd [HAZ_DEPTH];
   logic [CNT_W-1:0]     raw_cnt;

   logic match_rs1;
   logic match_rs2;
   logic hit_rs1;
   logic hit_rs2;
   logic raw;
   logic sb_shift;
   logic sb_load;
   logic cnt_inc;
   logic new_valid;

   always_comb begin
      match_rs1 = 1'b0;
      match_rs2 = 1'b0;
      for (int k = 0; k < HAZ_DEPTH; k++) begin
         if (sb_valid[k] && (sb_rd[k] == i_id_rs1_addr)) match_rs1 = 1'b1;
         if (sb_valid[k] && (sb_rd[k] == i_id_rs2_addr)) match_rs2 = 1'b1;
      end
   end

   // x0 is hardwired, so reading it never waits on anything in flight
   assign hit_rs1 = i_id_valid & i_id_rs1_used & (i_id_rs1_addr != 5'd0) & match_rs1;
   assign hit_rs2 = i_id_valid & i_id_rs2_used & (i_id_rs2_addr != 5'd0) & match_rs2;
   assign raw     = hit_rs1 | hit_rs2;

   // Priority: freeze, flush, raw, normal. Reset forces every control low.
   always_comb begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_ifid_flush  = 1'b0;
      o_idex_en     = 1'b0;
      o_idex_bubble = 1'b0;
      o_raw_stall   = 1'b0;
      sb_shift      = 1'b0;
      sb_load       = 1'b0;
      cnt_inc       = 1'b0;
      if (!i_reset && !i_stall_load) begin
         sb_shift = 1'b1;
         if (i_flush) begin
            o_pc_en       = 1'b1;
            o_ifid_en     = 1'b1;
            o_ifid_flush  = 1'b1;
            o_idex_en     = 1'b1;
            o_idex_bubble = 1'b1;
         end else if (raw) begin
            o_idex_en     = 1'b1;
            o_idex_bubble = 1'b1;
            o_raw_stall   = 1'b1;
            cnt_inc       = 1'b1;
         end else begin
            o_pc_en   = 1'b1;
            o_ifid_en = 1'b1;
            o_idex_en = 1'b1;
            sb_load   = 1'b1;
         end
      end
   end

   assign new_valid = sb_load & i_id_valid & i_id_rd_wren & (i_id_rd_addr != 5'd0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sb_valid <= '0;
         for (int k = 0; k < HAZ_DEPTH; k++) sb_rd[k] <= 5'd0;
      end else if (sb_shift) begin
         for (int k = HAZ_DEPTH - 1; k > 0; k--) begin
            sb_valid[k] <= sb_valid[k-1];
            sb_rd[k]    <= sb_rd[k-1];
         end
         sb_valid[0] <= new_valid;
         sb_rd[0]    <= i_id_rd_addr;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         raw_cnt <= '0;
      end else if (cnt_inc && (raw_cnt != {CNT_W{1'b1}})) begin
         raw_cnt <= raw_cnt + 1'b1;
      end
   end

   assign o_raw_stall_cnt = i_reset ? '0 : raw_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver pushes hand-computed expected controls
// into a queue, and a negedge monitor pops and compares them against the DUT each cycle.
module tb_hazard_scoreboard;

   localparam int HAZ_DEPTH = 3;
   localparam int CNT_W     = 4;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, raw_stall}
   localparam logic [5:0] C_NORM  = 6'b110100;
   localparam logic [5:0] C_RAW   = 6'b000111;
   localparam logic [5:0] C_FLUSH = 6'b111110;
   localparam logic [5:0] C_ZERO  = 6'b000000;

   logic             i_clk;
   logic             i_reset;
   logic             i_id_valid;
   logic [4:0]       i_id_rs1_addr;
   logic             i_id_rs1_used;
   logic [4:0]       i_id_rs2_addr;
   logic             i_id_rs2_used;
   logic [4:0]       i_id_rd_addr;
   logic             i_id_rd_wren;
   logic             i_stall_load;
   logic             i_flush;
   logic             o_pc_en;
   logic             o_ifid_en;
   logic             o_ifid_flush;
   logic             o_idex_en;
   logic             o_idex_bubble;
   logic             o_raw_stall;
   logic [CNT_W-1:0] o_raw_stall_cnt;

   logic [5+CNT_W:0] exp_q[$];
   string            name_q[$];
   int               checks = 0;
   int               errors = 0;

   logic [5+CNT_W:0] mon_exp;
   logic [5+CNT_W:0] mon_got;
   string            mon_name;

   hazard_scoreboard #(.HAZ_DEPTH(HAZ_DEPTH), .CNT_W(CNT_W)) dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_id_valid      (i_id_valid),
      .i_id_rs1_addr   (i_id_rs1_addr),
      .i_id_rs1_used   (i_id_rs1_used),
      .i_id_rs2_addr   (i_id_rs2_addr),
      .i_id_rs2_used   (i_id_rs2_used),
      .i_id_rd_addr    (i_id_rd_addr),
      .i_id_rd_wren    (i_id_rd_wren),
      .i_stall_load    (i_stall_load),
      .i_flush         (i_flush),
      .o_pc_en         (o_pc_en),
      .o_ifid_en       (o_ifid_en),
      .o_ifid_flush    (o_ifid_flush),
      .o_idex_en       (o_idex_en),
      .o_idex_bubble   (o_idex_bubble),
      .o_raw_stall     (o_raw_stall),
      .o_raw_stall_cnt (o_raw_stall_cnt)
   );

   // clock / reset
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1);
   end

   // driver tasks
   task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic w);
      i_id_valid    = v;
      i_id_rs1_addr = rs1;
      i_id_rs1_used = u1;
      i_id_rs2_addr = rs2;
      i_id_rs2_used = u2;
      i_id_rd_addr  = rd;
      i_id_rd_wren  = w;
   endtask

   task automatic cycle(input logic rst, input logic stall, input logic flush,
                        input logic [5:0] ctl, input logic [CNT_W-1:0] cnt, input string name);
      i_reset      = rst;
      i_stall_load = stall;
      i_flush      = flush;
      exp_q.push_back({ctl, cnt});
      name_q.push_back(name);
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [CNT_W-1:0] cnt);
      id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, C_NORM, cnt, "idle");
   endtask

   function automatic logic [CNT_W-1:0] sat(input int s);
      return (s > 15) ? 4'd15 : 4'(s);
   endfunction

   // scoreboard monitor
   always @(negedge i_clk) begin
      if (exp_q.size() != 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_got  = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_bubble,
                     o_raw_stall, o_raw_stall_cnt};
         checks++;
         if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d", mon_name,
                     mon_got[5+CNT_W:CNT_W], mon_got[CNT_W-1:0],
                     mon_exp[5+CNT_W:CNT_W], mon_exp[CNT_W-1:0]);
         end
      end
   end

   initial begin
      int s;
      i_reset = 1'b1;
      i_stall_load = 1'b0;
      i_flush = 1'b0;
      id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      @(posedge i_clk);
      #1;

      // reset with random inputs: everything low
      for (int i = 0; i < 4; i++) begin
         id_set(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), C_ZERO, 4'd0, "reset");
      end
      idle(2, 4'd0);

      // back-to-back RAW: 3 stall cycles
      id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd0, "b2b_prod");
      id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd0, "b2b_stall1");
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd1, "b2b_stall2");
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd2, "b2b_stall3");
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd3, "b2b_issue");
      idle(3, 4'd3);

      // x0 and unused/invalid sources never stall
      id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd3, "x0_prod");
      id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd3, "x0_consumer");
      id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd3, "unused_prod");
      id_set(1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd3, "rs2_unused");
      id_set(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd3, "id_invalid");
      idle(3, 4'd3);

      // one independent instruction between: 2 stall cycles on rs2
      id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd3, "gap_prod");
      id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd3, "gap_indep");
      id_set(1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd3, "gap_stall1");
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd4, "gap_stall2");
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd5, "gap_issue");
      idle(3, 4'd5);

      // load freeze in the middle of a RAW stall
      id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd5, "frz_prod");
      id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd5, "frz_stall1");
      cycle(1'b0, 1'b1, 1'b0, C_ZERO, 4'd6, "frz_freeze");
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd6, "frz_stall2");
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd7, "frz_stall3");
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd8, "frz_issue");
      idle(3, 4'd8);

      // flush on the second stall cycle, then freeze beats a simultaneous flush
      id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd8, "fl_prod");
      id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd8, "fl_stall1");
      cycle(1'b0, 1'b0, 1'b1, C_FLUSH, 4'd9, "fl_flush");
      id_set(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd9, "fl_next_indep");
      cycle(1'b0, 1'b1, 1'b1, C_ZERO, 4'd9, "freeze_and_flush");
      idle(3, 4'd9);

      // reset asserted mid-stall, then resume with an empty scoreboard
      id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd9, "rst_prod");
      id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, C_RAW, 4'd9, "rst_stall1");
      cycle(1'b1, 1'b0, 1'b0, C_ZERO, 4'd0, "reset_mid_stall");
      cycle(1'b0, 1'b0, 1'b0, C_NORM, 4'd0, "resume_after_reset");

      // counter saturation: 21 RAW stall cycles on a 4-bit counter
      s = 0;
      for (int r = 0; r < 7; r++) begin
         id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
         cycle(1'b0, 1'b0, 1'b0, C_NORM, sat(s), "sat_prod");
         id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
         for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, C_RAW, sat(s), "sat_stall");
            s++;
         end
         cycle(1'b0, 1'b0, 1'b0, C_NORM, sat(s), "sat_issue");
      end
      idle(1, 4'd15);

      @(negedge i_clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
